// File: rtl/rv_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | rv_ctrl_pkg: opcodes, ALUOp encodings and the decoded control bundle |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rv_ctrl_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_SB = 7'b1100011;
  localparam logic [6:0] OP_L  = 7'b0000011;

  localparam int CTRL_W = 8;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Field order is fixed so the bundle packs to the same 8-bit word everywhere.
  typedef struct packed {
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// +----------------------------------------------------------------------+
// | hazard_detect: load-use hazard between the EX load and the ID reader |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_detect
  import rv_ctrl_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic             id_alu_src,
  input  logic             id_mem_write,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             hazard
);

  logic w_uses_rs2;
  logic w_load_in_ex;
  logic w_rs1_match;
  logic w_rs2_match;

  // I-type and loads take the immediate, so their rs2 field is not a real read.
  assign w_uses_rs2   = ~id_alu_src | id_mem_write;
  assign w_load_in_ex = ex_valid & ex_mem_read & (ex_rd != '0);
  assign w_rs1_match  = (ex_rd == id_rs1);
  assign w_rs2_match  = w_uses_rs2 & (ex_rd == id_rs2);

  assign hazard = w_load_in_ex & id_valid & (w_rs1_match | w_rs2_match);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +----------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with load-use stall and flush   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module id_ex_stage
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [1:0]       id_alu_op,
  input  logic [3:0]       id_funct,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             flush,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic [1:0]       ex_alu_op,
  output logic [3:0]       ex_funct,
  output logic [REG_W-1:0] ex_rs1,
  output logic [REG_W-1:0] ex_rs2,
  output logic [REG_W-1:0] ex_rd,
  output logic [XLEN-1:0]  ex_rdata1,
  output logic [XLEN-1:0]  ex_rdata2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_t            r_ctrl;
  logic             r_valid;
  logic [3:0]       r_funct;
  logic [REG_W-1:0] r_rs1;
  logic [REG_W-1:0] r_rs2;
  logic [REG_W-1:0] r_rd;
  logic [XLEN-1:0]  r_rdata1;
  logic [XLEN-1:0]  r_rdata2;
  logic [XLEN-1:0]  r_imm;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ctrl_t w_id_ctrl;
  logic  w_hazard;
  logic  w_stall;
  logic  w_bubble;

  assign w_id_ctrl = '{alu_src:    id_alu_src,
                       mem_to_reg: id_mem_to_reg,
                       reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       branch:     id_branch,
                       alu_op:     alu_op_e'(id_alu_op)};

  hazard_detect u_hazard_detect (
    .ex_valid     (r_valid),
    .ex_mem_read  (r_ctrl.mem_read),
    .ex_rd        (r_rd),
    .id_valid     (id_valid),
    .id_alu_src   (id_alu_src),
    .id_mem_write (id_mem_write),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .hazard       (w_hazard)
  );

  // A flush already discards the ID instruction, and reset must leave the PC free.
  assign w_stall     = w_hazard & ~flush & rst_n;
  assign w_bubble    = flush | w_stall;
  assign pc_write    = ~w_stall;
  assign if_id_write = ~w_stall;

  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_funct  <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
    end else begin
      r_valid  <= id_valid;
      r_ctrl   <= id_valid ? w_id_ctrl : '0;
      r_funct  <= id_funct;
      r_rs1    <= id_rs1;
      r_rs2    <= id_rs2;
      r_rd     <= id_rd;
      r_rdata1 <= id_rdata1;
      r_rdata2 <= id_rdata2;
      r_imm    <= id_imm;
      r_pc     <= id_pc;
    end
  end

  // Counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_branch     = r_ctrl.branch;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_funct      = r_funct;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_rdata1     = r_rdata1;
  assign ex_rdata2     = r_rdata2;
  assign ex_imm        = r_imm;
  assign ex_pc         = r_pc;
  assign stall_count   = r_stall_cnt;
  assign flush_count   = r_flush_cnt;

endmodule

`default_nettype wire
